// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: FSM states, special key codes, keymap helpers.
// Latency: none (types and pure functions only).
// Backpressure: none (no handshake; consumers sample the keypad-event outputs directly).
package keypad_pkg;

    typedef enum logic [2:0] {
        SCAN     = 3'd0,
        DEBOUNCE = 3'd1,
        HELD     = 3'd2,
        RELEASE  = 3'd3,
        CLEAR    = 3'd4
    } kp_state_t;

    localparam logic [3:0] KEY_CLEAR  = 4'd7;
    localparam logic [3:0] KEY_REPROG = 4'd8;
    localparam logic [3:0] KEY_LOCK   = 4'd9;

    // All columns pulled high: no key contact in the driven row.
    localparam logic [3:0] COL_IDLE   = 4'hF;

    // Keymap: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D.
    function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'd0;
        case ({row, col})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h3: code = 4'd10;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h7: code = 4'd11;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hB: code = 4'd12;
            4'hC: code = 4'd14;
            4'hD: code = 4'd0;
            4'hE: code = 4'd15;
            4'hF: code = 4'd13;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    // Index of the lowest-numbered active (low) column.
    function automatic logic [1:0] first_low(input logic [3:0] col);
        logic [1:0] idx;
        if (!col[0])      idx = 2'd0;
        else if (!col[1]) idx = 2'd1;
        else if (!col[2]) idx = 2'd2;
        else              idx = 2'd3;
        return idx;
    endfunction

    // True when more than one column is pulled low at once.
    function automatic logic multi_low(input logic [3:0] col);
        logic [2:0] n;
        n = 3'(!col[0]) + 3'(!col[1]) + 3'(!col[2]) + 3'(!col[3]);
        return (n > 3'd1);
    endfunction

endpackage

// File: rtl/keypad_stable_counter.sv
// Stability counter: cleared by load, counts up on inc, saturates at MAX_COUNT; tc at MAX_COUNT-1.
// Latency: count updates one cycle after load/inc; tc is combinational from the count.
// Backpressure: none.
module keypad_stable_counter #(
    parameter int MAX_COUNT = 240000,
    parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic inc,
    output logic tc
);

    logic [CNT_W-1:0] count;

    // Load wins over increment; hold at MAX_COUNT so the count never wraps.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (inc && (count != CNT_W'(MAX_COUNT))) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == CNT_W'(MAX_COUNT - 1));

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 keypad scanner: row scan, 2-flop column sync, debounce, one encoded key event per press.
// Latency: press accepted DEBOUNCE_CYCLES+2 cycles after stable contact at slot end; release likewise.
// Backpressure: none; optional KEYPAD_MULTIKEY_REJECT_EN rejects multi-column presses via multi_key.
module keypad_scan_encoder #(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic       hwclk,
    input  logic       reset_n,
    input  logic [3:0] kp_col,
    output logic [3:0] kp_row,
    output logic [3:0] button,
    output logic       bstate,
    output logic       read_input,
    output logic       multi_key
);

    import keypad_pkg::*;

    localparam int SLOT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_CYCLES - 1);

    logic [3:0]        col_s1;
    logic [3:0]        col_s;
    kp_state_t         state, state_nxt;
    logic [1:0]        row_idx, row_nxt;
    logic [SLOT_W-1:0] slot_cnt, slot_nxt;
    logic              running;
    logic [3:0]        col_lat, col_lat_nxt;
    logic [3:0]        code_lat, code_lat_nxt;
    logic              cnt_load, cnt_inc, cnt_tc;
    logic              accept, release_done;
`ifdef KEYPAD_MULTIKEY_REJECT_EN
    logic              mk_hit;
`endif

    // Columns are asynchronous to hwclk: two-flop synchronizer, idle value is all-high.
    always_ff @(posedge hwclk) begin
        if (!reset_n) begin
            col_s1 <= COL_IDLE;
            col_s  <= COL_IDLE;
        end else begin
            col_s1 <= kp_col;
            col_s  <= col_s1;
        end
    end

    keypad_stable_counter #(
        .MAX_COUNT (DEBOUNCE_CYCLES)
    ) u_stable_cnt (
        .clk     (hwclk),
        .reset_n (reset_n),
        .load    (cnt_load),
        .inc     (cnt_inc),
        .tc      (cnt_tc)
    );

    // Next-state logic: scan slots, press debounce, hold, release debounce, one-cycle clear.
    always_comb begin
        state_nxt    = state;
        row_nxt      = row_idx;
        slot_nxt     = slot_cnt;
        col_lat_nxt  = col_lat;
        code_lat_nxt = code_lat;
        cnt_load     = 1'b0;
        cnt_inc      = 1'b0;
        accept       = 1'b0;
        release_done = 1'b0;
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        mk_hit       = 1'b0;
`endif
        case (state)
            SCAN: begin
                if (running) begin
                    if (slot_cnt != SLOT_LAST) begin
                        slot_nxt = slot_cnt + SLOT_W'(1);
                    end else begin
                        slot_nxt = '0;
                        cnt_load = 1'b1;
                        if (col_s == COL_IDLE) begin
                            row_nxt = row_idx + 2'd1;
`ifdef KEYPAD_MULTIKEY_REJECT_EN
                        end else if (multi_low(col_s)) begin
                            mk_hit  = 1'b1;
                            row_nxt = row_idx + 2'd1;
`endif
                        end else begin
                            col_lat_nxt  = col_s;
                            code_lat_nxt = keymap(row_idx, first_low(col_s));
                            state_nxt    = DEBOUNCE;
                        end
                    end
                end
            end
            DEBOUNCE: begin
                if (col_s != col_lat) begin
                    state_nxt = SCAN;
                    row_nxt   = row_idx + 2'd1;
                    slot_nxt  = '0;
                    cnt_load  = 1'b1;
                end else if (cnt_tc) begin
                    accept    = 1'b1;
                    state_nxt = HELD;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            HELD: begin
                // Only a full release matters; extra keys while held are ignored.
                if (col_s == COL_IDLE) begin
                    state_nxt = RELEASE;
                    cnt_load  = 1'b1;
                end
            end
            RELEASE: begin
                if (col_s != COL_IDLE) begin
                    state_nxt = HELD;
                end else if (cnt_tc) begin
                    release_done = 1'b1;
                    state_nxt    = CLEAR;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            CLEAR: begin
                cnt_load  = 1'b1;
                row_nxt   = 2'd0;
                slot_nxt  = '0;
                state_nxt = SCAN;
            end
            default: begin
                state_nxt = SCAN;
                row_nxt   = 2'd0;
                slot_nxt  = '0;
            end
        endcase
    end

    // State register plus scan position and latched candidate key.
    always_ff @(posedge hwclk) begin
        if (!reset_n) begin
            state    <= SCAN;
            row_idx  <= 2'd0;
            slot_cnt <= '0;
            running  <= 1'b0;
            col_lat  <= COL_IDLE;
            code_lat <= 4'd0;
        end else begin
            state    <= state_nxt;
            row_idx  <= row_nxt;
            slot_cnt <= slot_nxt;
            running  <= 1'b1;
            col_lat  <= col_lat_nxt;
            code_lat <= code_lat_nxt;
        end
    end

    // Event outputs: read_input outlives bstate by one cycle so it is valid at the bstate fall.
    always_ff @(posedge hwclk) begin
        if (!reset_n) begin
            button     <= 4'd0;
            bstate     <= 1'b0;
            read_input <= 1'b0;
        end else begin
            if (accept) begin
                button     <= code_lat;
                bstate     <= 1'b1;
                read_input <= 1'b1;
            end
            if (release_done) begin
                bstate <= 1'b0;
            end
            if (state == CLEAR) begin
                read_input <= 1'b0;
            end
        end
    end

`ifdef KEYPAD_MULTIKEY_REJECT_EN
    // One-cycle flag for each rejected multi-column sample.
    always_ff @(posedge hwclk) begin
        if (!reset_n) begin
            multi_key <= 1'b0;
        end else begin
            multi_key <= mk_hit;
        end
    end
`else
    assign multi_key = 1'b0;
`endif

    // Rows idle high until scanning starts after reset, then exactly one row low.
    assign kp_row = running ? ~(4'b0001 << row_idx) : 4'b1111;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder with a behavioural 4x4 key matrix.
// Timing: inputs driven and outputs sampled on the falling edge of hwclk.
// Build with KEYPAD_MULTIKEY_REJECT_EN to exercise the multi-key rejection variant.
module tb_keypad_scan_encoder;

    localparam int SCAN_CYCLES     = 4;
    localparam int DEBOUNCE_CYCLES = 16;

    logic       hwclk;
    logic       reset_n;
    logic [3:0] kp_col;
    logic [3:0] kp_row;
    logic [3:0] button;
    logic       bstate;
    logic       read_input;
    logic       multi_key;

    logic [15:0] pressed;   // bit r*4+c = key at (row r, col c) closed

    int total;
    int bad;
    int rise_cnt;
    int mk_cnt;
    logic [3:0] fall_btn[$];
    logic bstate_q;

    keypad_scan_encoder #(
        .SCAN_CYCLES     (SCAN_CYCLES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .hwclk      (hwclk),
        .reset_n    (reset_n),
        .kp_col     (kp_col),
        .kp_row     (kp_row),
        .button     (button),
        .bstate     (bstate),
        .read_input (read_input),
        .multi_key  (multi_key)
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    // Key matrix: a closed key pulls its column low while its row is driven low.
    always_comb begin
        kp_col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!kp_row[r] && pressed[r*4+c]) kp_col[c] = 1'b0;
            end
        end
    end

    // Event monitor: counts presses, records button at each valid release event.
    initial bstate_q = 1'b0;
    always @(negedge hwclk) begin
        if (bstate && !bstate_q) rise_cnt++;
        if (!bstate && bstate_q && read_input) fall_btn.push_back(button);
        if (multi_key) mk_cnt++;
        bstate_q = bstate;
    end

    task automatic wait_bstate(input logic lvl, input int budget, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        while (n < budget) begin
            @(negedge hwclk);
            n++;
            if (bstate === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic press_release(input int idx, output bit ok_rise, output bit ok_fall);
        int n;
        pressed[idx] = 1'b1;
        wait_bstate(1'b1, 100, ok_rise, n);
        repeat (3) @(negedge hwclk);
        pressed[idx] = 1'b0;
        wait_bstate(1'b0, 60, ok_fall, n);
        repeat (3) @(negedge hwclk);
    endtask

    task automatic test_reset;
        logic [3:0] exp_row;
        reset_n = 1'b0;
        pressed = '0;
        repeat (3) @(negedge hwclk);
        total++; if (kp_row !== 4'b1111) begin bad++; $display("FAIL reset_kp_row got=%b want=1111", kp_row); end
        total++; if (button !== 4'd0) begin bad++; $display("FAIL reset_button got=%0d want=0", button); end
        total++; if (bstate !== 1'b0) begin bad++; $display("FAIL reset_bstate got=%b want=0", bstate); end
        total++; if (read_input !== 1'b0) begin bad++; $display("FAIL reset_read_input got=%b want=0", read_input); end
        total++; if (multi_key !== 1'b0) begin bad++; $display("FAIL reset_multi_key got=%b want=0", multi_key); end
        reset_n = 1'b1;
        // Scan order: row 0..3, SCAN_CYCLES cycles each, starting the cycle after reset release.
        for (int i = 0; i < 4 * SCAN_CYCLES; i++) begin
            @(negedge hwclk);
            exp_row = ~(4'b0001 << (i / SCAN_CYCLES));
            total++;
            if (kp_row !== exp_row) begin
                bad++;
                $display("FAIL scan_order cyc=%0d got=%b want=%b", i, kp_row, exp_row);
            end
        end
    endtask

    task automatic test_key9;
        int r0;
        int n;
        bit seen;
        bit ok;
        logic [3:0] btn_at_rise;
        logic ri_at_rise;
        r0 = rise_cnt;
        seen = 1'b0;
        btn_at_rise = 4'd0;
        ri_at_rise = 1'b0;
        pressed[10] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge hwclk);
            if (bstate && !seen) begin
                seen = 1'b1;
                btn_at_rise = button;
                ri_at_rise = read_input;
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL key9_press no bstate rise within 40 cycles"); end
        total++; if (btn_at_rise !== 4'd9) begin bad++; $display("FAIL key9_button got=%0d want=9", btn_at_rise); end
        total++; if (ri_at_rise !== 1'b1) begin bad++; $display("FAIL key9_read_input got=%b want=1", ri_at_rise); end
        total++; if (rise_cnt - r0 != 1) begin bad++; $display("FAIL key9_rises got=%0d want=1", rise_cnt - r0); end
        pressed[10] = 1'b0;
        wait_bstate(1'b0, 60, ok, n);
        total++; if (!ok) begin bad++; $display("FAIL key9_release timeout after %0d cycles", n); end
        // 2 sync cycles + 1 cycle to enter RELEASE + DEBOUNCE_CYCLES counting.
        total++; if (n != DEBOUNCE_CYCLES + 3) begin bad++; $display("FAIL key9_release_latency got=%0d want=%0d", n, DEBOUNCE_CYCLES + 3); end
        total++; if (read_input !== 1'b1) begin bad++; $display("FAIL key9_ri_at_fall got=%b want=1", read_input); end
        @(negedge hwclk);
        total++; if (read_input !== 1'b0) begin bad++; $display("FAIL key9_ri_after_fall got=%b want=0", read_input); end
        repeat (4) @(negedge hwclk);
    endtask

    task automatic test_bounce;
        int r0;
        int f0;
        int n;
        bit ok;
        r0 = rise_cnt;
        f0 = fall_btn.size();
        for (int i = 0; i < 10; i++) begin
            pressed[9] = (i % 2 == 0);
            repeat (3) @(negedge hwclk);
        end
        pressed[9] = 1'b1;
        repeat (40) @(negedge hwclk);
        pressed[9] = 1'b0;
        wait_bstate(1'b0, 60, ok, n);
        repeat (4) @(negedge hwclk);
        total++; if (!ok) begin bad++; $display("FAIL bounce_release timeout after %0d cycles", n); end
        total++; if (rise_cnt - r0 != 1) begin bad++; $display("FAIL bounce_rises got=%0d want=1", rise_cnt - r0); end
        total++;
        if (fall_btn.size() != f0 + 1) begin
            bad++; $display("FAIL bounce_events got=%0d want=1", fall_btn.size() - f0);
        end else if (fall_btn[f0] !== 4'd8) begin
            bad++; $display("FAIL bounce_button got=%0d want=8", fall_btn[f0]);
        end
    endtask

    task automatic test_glitch;
        int r0;
        int n;
        int stay;
        r0 = rise_cnt;
        n = 0;
        while (kp_row !== 4'b0111 && n < 40) begin @(negedge hwclk); n++; end
        while (kp_row !== 4'b1110 && n < 40) begin @(negedge hwclk); n++; end
        total++; if (kp_row !== 4'b1110) begin bad++; $display("FAIL glitch_sync row0 not reached, kp_row=%b", kp_row); end
        pressed[0] = 1'b1;
        stay = 0;
        for (int i = 0; i < 10; i++) begin
            if (kp_row === 4'b1110) stay++;
            @(negedge hwclk);
        end
        pressed[0] = 1'b0;
        n = 0;
        while (kp_row === 4'b1110 && n < 40) begin stay++; @(negedge hwclk); n++; end
        total++; if (stay <= SCAN_CYCLES) begin bad++; $display("FAIL glitch_debounce row0 held %0d cycles, want >%0d", stay, SCAN_CYCLES); end
        total++; if (kp_row !== 4'b1101) begin bad++; $display("FAIL glitch_next_row got=%b want=1101", kp_row); end
        repeat (30) @(negedge hwclk);
        total++; if (rise_cnt != r0) begin bad++; $display("FAIL glitch_rises got=%0d want=0", rise_cnt - r0); end
    endtask

    task automatic test_multi_key;
        int r0;
        int f0;
        int m0;
        r0 = rise_cnt;
        f0 = fall_btn.size();
        m0 = mk_cnt;
        pressed[4] = 1'b1;
        pressed[6] = 1'b1;
        repeat (40) @(negedge hwclk);
        pressed[4] = 1'b0;
        pressed[6] = 1'b0;
        repeat (30) @(negedge hwclk);
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        total++; if (mk_cnt == m0) begin bad++; $display("FAIL multi_pulse got=0 want>=1"); end
        total++; if (rise_cnt != r0) begin bad++; $display("FAIL multi_rises got=%0d want=0", rise_cnt - r0); end
`else
        total++; if (mk_cnt != m0) begin bad++; $display("FAIL multi_tied got=%0d pulses want=0", mk_cnt - m0); end
        total++;
        if (fall_btn.size() != f0 + 1) begin
            bad++; $display("FAIL multi_events got=%0d want=1", fall_btn.size() - f0);
        end else if (fall_btn[f0] !== 4'd4) begin
            bad++; $display("FAIL multi_button got=%0d want=4", fall_btn[f0]);
        end
`endif
    endtask

    task automatic test_reset_held;
        int f0;
        int r0;
        int n;
        bit ok;
        f0 = fall_btn.size();
        r0 = rise_cnt;
        pressed[5] = 1'b1;
        wait_bstate(1'b1, 100, ok, n);
        total++; if (!ok) begin bad++; $display("FAIL rsthold_press timeout after %0d cycles", n); end
        repeat (2) @(negedge hwclk);
        reset_n = 1'b0;
        @(negedge hwclk);
        total++; if (bstate !== 1'b0) begin bad++; $display("FAIL rsthold_bstate got=%b want=0", bstate); end
        total++; if (read_input !== 1'b0) begin bad++; $display("FAIL rsthold_read_input got=%b want=0", read_input); end
        total++; if (kp_row !== 4'b1111) begin bad++; $display("FAIL rsthold_kp_row got=%b want=1111", kp_row); end
        total++; if (button !== 4'd0) begin bad++; $display("FAIL rsthold_button got=%0d want=0", button); end
        pressed[5] = 1'b0;
        reset_n = 1'b1;
        repeat (30) @(negedge hwclk);
        total++; if (fall_btn.size() != f0) begin bad++; $display("FAIL rsthold_events got=%0d want=0", fall_btn.size() - f0); end
        total++; if (rise_cnt - r0 != 1) begin bad++; $display("FAIL rsthold_rises got=%0d want=1", rise_cnt - r0); end
    endtask

    task automatic test_back_to_back;
        int idx_list[6];
        logic [3:0] exp_code[6];
        int f0;
        int r0;
        bit ok_r;
        bit ok_f;
        idx_list = '{9, 0, 1, 2, 4, 9};
        exp_code = '{4'd8, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8};
        f0 = fall_btn.size();
        r0 = rise_cnt;
        for (int k = 0; k < 6; k++) begin
            press_release(idx_list[k], ok_r, ok_f);
            total++;
            if (!(ok_r && ok_f)) begin
                bad++; $display("FAIL seq_timeout key#%0d rise_ok=%0b fall_ok=%0b", k, ok_r, ok_f);
            end
        end
        total++; if (rise_cnt - r0 != 6) begin bad++; $display("FAIL seq_rises got=%0d want=6", rise_cnt - r0); end
        total++;
        if (fall_btn.size() != f0 + 6) begin
            bad++; $display("FAIL seq_events got=%0d want=6", fall_btn.size() - f0);
        end
        for (int k = 0; k < 6; k++) begin
            if (f0 + k < fall_btn.size()) begin
                total++;
                if (fall_btn[f0+k] !== exp_code[k]) begin
                    bad++; $display("FAIL seq_button#%0d got=%0d want=%0d", k, fall_btn[f0+k], exp_code[k]);
                end
            end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rise_cnt = 0;
        mk_cnt   = 0;
        reset_n  = 1'b0;
        pressed  = '0;
        test_reset();
        test_key9();
        test_bounce();
        test_glitch();
        test_multi_key();
        test_reset_held();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
